multdiv_sequencer: RTL and testbench

Sequences the shared multicycle multiplier/divider for the execute stage of the pipeline processor. It detects a mult or div instruction in execute from the decoded ALU opcode and issues a one-cycle start pulse to the multdiv unit. It then stalls the front of the pipeline until the unit reports ready or a cycle budget expires, and presents a registered result, exception flag and one-cycle valid to the execute/memory latch.

---
 rtl/multdiv_sequencer.sv | 116 +++++++++++
 tb/tb_multdiv_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_sequencer.sv
// Execute-stage sequencer for the shared multicycle multiplier/divider:
// issues the start pulse, stalls the front end and registers the outcome.
module multdiv_sequencer #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 32,
  parameter int DIV_CYCLES  = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic [4:0]       ALU_opcode,
  input  logic             flush,
  input  logic             md_rdy,
  input  logic             md_exception,
  input  logic [WIDTH-1:0] md_result,
  output logic             ctrl_mult,
  output logic             ctrl_div,
  output logic             stall,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             exc_out
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

  localparam logic [4:0]       OP_MULT   = 5'b00110;
  localparam logic [4:0]       OP_DIV    = 5'b00111;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [WIDTH-1:0] result_nxt;
  logic             exc_nxt;
  logic             is_mult, is_div, start;

  assign is_mult = ex_valid & ~flush & (ALU_opcode == OP_MULT);
  assign is_div  = ex_valid & ~flush & (ALU_opcode == OP_DIV);
  assign start   = is_mult | is_div;
  assign busy    = (state != IDLE);

  always_comb begin
    state_nxt    = state;
    count_nxt    = count;
    result_nxt   = result;
    exc_nxt      = exc_out;
    ctrl_mult    = 1'b0;
    ctrl_div     = 1'b0;
    stall        = 1'b0;
    result_valid = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          ctrl_mult = is_mult;
          ctrl_div  = is_div;
          stall     = 1'b1;
          count_nxt = is_mult ? MULT_LOAD : DIV_LOAD;
          state_nxt = RUN;
        end
      end
      RUN: begin
        stall = 1'b1;
        if (flush) begin
          state_nxt = IDLE;
        end else if (md_rdy) begin
          result_nxt = md_result;
          exc_nxt    = md_exception;
          state_nxt  = DONE;
        end else if (count == CNT_ONE) begin
          // Budget exhausted: report as an exception with a zero result.
          result_nxt = '0;
          exc_nxt    = 1'b1;
          state_nxt  = DONE;
        end else begin
          count_nxt = count - CNT_ONE;
        end
      end
      DONE: begin
        result_valid = ~flush;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Control strobes must stay quiet while reset is being applied.
    if (!reset) begin
      ctrl_mult    = 1'b0;
      ctrl_div     = 1'b0;
      stall        = 1'b0;
      result_valid = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= IDLE;
      count   <= '0;
      result  <= '0;
      exc_out <= 1'b0;
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      result  <= result_nxt;
      exc_out <= exc_nxt;
    end
  end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed per-cycle vector bench for multdiv_sequencer (MULT budget 8, DIV budget 4).
module tb_multdiv_sequencer;

  localparam logic [4:0] MUL = 5'b00110;
  localparam logic [4:0] DIV = 5'b00111;
  localparam logic [4:0] ADD = 5'b00000;

  logic        clock = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [4:0]  ALU_opcode;
  logic        flush;
  logic        md_rdy;
  logic        md_exception;
  logic [31:0] md_result;
  logic        ctrl_mult, ctrl_div, stall, busy, result_valid, exc_out;
  logic [31:0] result;

  int n_vec  = 0;
  int n_fail = 0;

  multdiv_sequencer #(
    .WIDTH      (32),
    .MULT_CYCLES(8),
    .DIV_CYCLES (4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .ex_valid    (ex_valid),
    .ALU_opcode  (ALU_opcode),
    .flush       (flush),
    .md_rdy      (md_rdy),
    .md_exception(md_exception),
    .md_result   (md_result),
    .ctrl_mult   (ctrl_mult),
    .ctrl_div    (ctrl_div),
    .stall       (stall),
    .busy        (busy),
    .result      (result),
    .result_valid(result_valid),
    .exc_out     (exc_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rn, ev;
    logic [4:0]  op;
    logic        fl, rdy, exc;
    logic [31:0] mr;
    logic        cm, cd, st, bz, rv;
    logic [31:0] res;
    logic        exo;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t v(input logic rn, input logic ev, input logic [4:0] op,
                             input logic fl, input logic rdy, input logic exc,
                             input logic [31:0] mr, input logic cm, input logic cd,
                             input logic st, input logic bz, input logic rv,
                             input logic [31:0] res, input logic exo);
    vec_t t;
    t.rn = rn; t.ev = ev; t.op = op; t.fl = fl; t.rdy = rdy; t.exc = exc; t.mr = mr;
    t.cm = cm; t.cd = cd; t.st = st; t.bz = bz; t.rv = rv; t.res = res; t.exo = exo;
    return t;
  endfunction

  task automatic drive(input logic rn, input logic ev, input logic [4:0] op,
                       input logic fl, input logic rdy, input logic exc,
                       input logic [31:0] mr);
    reset = rn; ex_valid = ev; ALU_opcode = op; flush = fl;
    md_rdy = rdy; md_exception = exc; md_result = mr;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, got, exp);
    end
  endtask

  task automatic check_word(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  initial begin
    // Mult answered at cycle 5 with 0xC35
    tv.push_back(v(1,1,MUL,0,0,0,32'h0,   1,0,1,0,0,32'h0,0));
    for (int i = 1; i <= 4; i++)
      tv.push_back(v(1,1,MUL,0,0,0,32'h0, 0,0,1,1,0,32'h0,0));
    tv.push_back(v(1,1,MUL,0,1,0,32'hC35, 0,0,1,1,0,32'h0,0));
    tv.push_back(v(1,1,MUL,0,0,0,32'h0,   0,0,0,1,1,32'hC35,0));
    tv.push_back(v(1,0,ADD,0,0,0,32'h0,   0,0,0,0,0,32'hC35,0));
    // Div timeout with budget 4
    tv.push_back(v(1,1,DIV,0,0,0,32'h0,   0,1,1,0,0,32'hC35,0));
    for (int i = 1; i <= 4; i++)
      tv.push_back(v(1,1,DIV,0,0,0,32'h0, 0,0,1,1,0,32'hC35,0));
    tv.push_back(v(1,1,DIV,0,0,0,32'h0,   0,0,0,1,1,32'h0,1));
    tv.push_back(v(1,0,ADD,0,0,0,32'h0,   0,0,0,0,0,32'h0,1));
    // Div answered at cycle 1 with divide-by-zero
    tv.push_back(v(1,1,DIV,0,0,0,32'h0,   0,1,1,0,0,32'h0,1));
    tv.push_back(v(1,1,DIV,0,1,1,32'h1234,0,0,1,1,0,32'h0,1));
    tv.push_back(v(1,1,DIV,0,0,0,32'h0,   0,0,0,1,1,32'h1234,1));
    tv.push_back(v(1,0,ADD,0,0,0,32'h0,   0,0,0,0,0,32'h1234,1));
    // Flush in RUN at cycle 3 coinciding with md_rdy, then flush with start
    tv.push_back(v(1,1,MUL,0,0,0,32'h0,   1,0,1,0,0,32'h1234,1));
    tv.push_back(v(1,1,MUL,0,0,0,32'h0,   0,0,1,1,0,32'h1234,1));
    tv.push_back(v(1,1,MUL,0,0,0,32'h0,   0,0,1,1,0,32'h1234,1));
    tv.push_back(v(1,1,MUL,1,1,0,32'hBEEF,0,0,1,1,0,32'h1234,1));
    tv.push_back(v(1,0,ADD,0,0,0,32'h0,   0,0,0,0,0,32'h1234,1));
    tv.push_back(v(1,1,MUL,1,0,0,32'h0,   0,0,0,0,0,32'h1234,1));
    tv.push_back(v(1,1,ADD,0,0,0,32'h0,   0,0,0,0,0,32'h1234,1));
    tv.push_back(v(1,0,MUL,0,1,0,32'h99,  0,0,0,0,0,32'h1234,1));
    tv.push_back(v(1,0,ADD,0,0,0,32'h0,   0,0,0,0,0,32'h1234,1));
    // Back-to-back mults, each answered at cycle 3
    tv.push_back(v(1,1,MUL,0,0,0,32'h0,   1,0,1,0,0,32'h1234,1));
    tv.push_back(v(1,1,MUL,0,0,0,32'h0,   0,0,1,1,0,32'h1234,1));
    tv.push_back(v(1,1,MUL,0,0,0,32'h0,   0,0,1,1,0,32'h1234,1));
    tv.push_back(v(1,1,MUL,0,1,0,32'h11,  0,0,1,1,0,32'h1234,1));
    tv.push_back(v(1,1,MUL,0,0,0,32'h0,   0,0,0,1,1,32'h11,0));
    tv.push_back(v(1,1,MUL,0,0,0,32'h0,   1,0,1,0,0,32'h11,0));
    tv.push_back(v(1,1,MUL,0,0,0,32'h0,   0,0,1,1,0,32'h11,0));
    tv.push_back(v(1,1,MUL,0,0,0,32'h0,   0,0,1,1,0,32'h11,0));
    tv.push_back(v(1,1,MUL,0,1,0,32'h22,  0,0,1,1,0,32'h11,0));
    tv.push_back(v(1,1,MUL,0,0,0,32'h0,   0,0,0,1,1,32'h22,0));
    tv.push_back(v(1,0,ADD,0,0,0,32'h0,   0,0,0,0,0,32'h22,0));
    // Flush during DONE drops the strobe but keeps the captured value
    tv.push_back(v(1,1,MUL,0,0,0,32'h0,   1,0,1,0,0,32'h22,0));
    tv.push_back(v(1,1,MUL,0,1,0,32'h77,  0,0,1,1,0,32'h22,0));
    tv.push_back(v(1,1,MUL,1,0,0,32'h0,   0,0,0,1,0,32'h77,0));
    tv.push_back(v(1,0,ADD,0,0,0,32'h0,   0,0,0,0,0,32'h77,0));
    // Reset mid-RUN, then a stray md_rdy in IDLE
    tv.push_back(v(1,1,DIV,0,0,0,32'h0,   0,1,1,0,0,32'h77,0));
    tv.push_back(v(1,1,DIV,0,0,0,32'h0,   0,0,1,1,0,32'h77,0));
    tv.push_back(v(0,1,DIV,0,0,0,32'h0,   0,0,0,1,0,32'h77,0));
    tv.push_back(v(1,0,ADD,0,0,0,32'h0,   0,0,0,0,0,32'h0,0));
    tv.push_back(v(1,0,ADD,0,1,1,32'h55,  0,0,0,0,0,32'h0,0));
    tv.push_back(v(1,0,ADD,0,0,0,32'h0,   0,0,0,0,0,32'h0,0));

    // Reset from power-up state, then verify the cleared state
    drive(0, 0, ADD, 0, 0, 0, 32'h0);
    tick();
    drive(0, 0, ADD, 0, 0, 0, 32'h0);
    #4;
    check_bit("reset_stall", stall, 1'b0);
    check_bit("reset_busy", busy, 1'b0);
    check_word("reset_result", result, 32'h0);
    check_bit("reset_exc", exc_out, 1'b0);
    tick();

    foreach (tv[i]) begin
      drive(tv[i].rn, tv[i].ev, tv[i].op, tv[i].fl, tv[i].rdy, tv[i].exc, tv[i].mr);
      #4;
      n_vec++;
      if ({ctrl_mult, ctrl_div, stall, busy, result_valid, exc_out, result} !==
          {tv[i].cm, tv[i].cd, tv[i].st, tv[i].bz, tv[i].rv, tv[i].exo, tv[i].res}) begin
        n_fail++;
        $display("FAIL row%0d: got cm=%b cd=%b st=%b bz=%b rv=%b exc=%b res=%h, expected cm=%b cd=%b st=%b bz=%b rv=%b exc=%b res=%h",
                 i, ctrl_mult, ctrl_div, stall, busy, result_valid, exc_out, result,
                 tv[i].cm, tv[i].cd, tv[i].st, tv[i].bz, tv[i].rv, tv[i].exo, tv[i].res);
      end
      tick();
    end

    // Mult timeout with budget 8: stall for cycles 0..8, DONE at cycle 9
    begin
      int  stall_cycles;
      logic ended;
      stall_cycles = 0;
      ended = 1'b0;
      for (int c = 0; c < 20 && !ended; c++) begin
        drive(1, 1, MUL, 0, 0, 0, 32'h0);
        #4;
        if (!stall) ended = 1'b1;
        else begin
          stall_cycles++;
          tick();
        end
      end
      check_bit("mult_timeout_ended", ended, 1'b1);
      check_word("mult_timeout_stall_cycles", 32'(stall_cycles), 32'd9);
      check_bit("mult_timeout_rv", result_valid, 1'b1);
      check_bit("mult_timeout_exc", exc_out, 1'b1);
      check_word("mult_timeout_result", result, 32'h0);
      tick();
    end

    // md_rdy on the last budgeted cycle wins over the timeout
    drive(1, 0, ADD, 0, 0, 0, 32'h0);
    tick();
    drive(1, 1, MUL, 0, 0, 0, 32'h0);
    tick();
    for (int c = 1; c <= 7; c++) tick();
    drive(1, 1, MUL, 0, 1, 0, 32'hABCD);
    #4;
    check_bit("last_cycle_rdy_stall", stall, 1'b1);
    tick();
    drive(1, 1, MUL, 0, 0, 0, 32'h0);
    #4;
    check_bit("last_cycle_rdy_rv", result_valid, 1'b1);
    check_word("last_cycle_rdy_result", result, 32'hABCD);
    check_bit("last_cycle_rdy_exc", exc_out, 1'b0);
    tick();
    drive(1, 0, ADD, 0, 0, 0, 32'h0);
    #4;
    check_bit("last_cycle_rdy_idle", busy, 1'b0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
